// File: rtl/dequant_4x4_pkg.sv
// -----------------------------------------------------------------------------
// dequant_4x4_pkg
//
// Shared definitions for the 4x4 inverse-quantizer (dequant_4x4) and its
// scale table (dequant_scale_lut):
//   - V_TABLE      : dequantization scale V per position class and QP%6
//   - pos_class_e  : position class of a raster index inside the 4x4 block
//   - state_e      : block-tracking FSM state
//   - QP_BY_6_MAX  : largest shift applied (QP/6 values above are clamped)
//   - pos_class()  : maps a raster index 0..15 to its position class
// -----------------------------------------------------------------------------
package dequant_4x4_pkg;

    // QP/6 values above this are clamped; also sizes the shifted datapath.
    localparam int QP_BY_6_MAX = 8;

    // Width of a V entry (largest entry is 29).
    localparam int V_W = 5;

    // Position classes of the 4x4 block:
    //   CLASS_A : even row, even column  {0,2,8,10}
    //   CLASS_B : odd row, odd column    {5,7,13,15}
    //   CLASS_C : all remaining positions
    typedef enum logic [1:0] {
        CLASS_A = 2'd0,
        CLASS_B = 2'd1,
        CLASS_C = 2'd2
    } pos_class_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Rows follow pos_class_e order, columns follow QP%6 = 0..5.
    localparam logic [V_W-1:0] V_TABLE [0:2][0:5] = '{
        '{5'd10, 5'd11, 5'd13, 5'd14, 5'd16, 5'd18},
        '{5'd16, 5'd18, 5'd20, 5'd23, 5'd25, 5'd29},
        '{5'd13, 5'd14, 5'd16, 5'd18, 5'd20, 5'd23}
    };

    function automatic pos_class_e pos_class(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd2, 4'd8, 4'd10:  return CLASS_A;
            4'd5, 4'd7, 4'd13, 4'd15: return CLASS_B;
            default:                  return CLASS_C;
        endcase
    endfunction

endpackage

// File: rtl/dequant_scale_lut.sv
// -----------------------------------------------------------------------------
// dequant_scale_lut
//
// Combinational scale lookup: the inverse-side counterpart of the forward
// quantizer's multiplier table. Returns V for a raster position and QP%6.
//
// Ports:
//   index     in  4    raster position 0..15 inside the 4x4 block
//   qp_mod_6  in  3    QP%6; codes 6 and 7 are treated as 0
//   v         out V_W  scale factor
// -----------------------------------------------------------------------------
module dequant_scale_lut
    import dequant_4x4_pkg::*;
(
    input  logic [3:0]     index,
    input  logic [2:0]     qp_mod_6,
    output logic [V_W-1:0] v
);

    pos_class_e cls;
    logic [2:0] mod_sel;

    always_comb begin
        cls     = pos_class(index);
        // Illegal QP%6 codes fall back to column 0 instead of reading past the table.
        mod_sel = (qp_mod_6 > 3'd5) ? 3'd0 : qp_mod_6;
        v       = V_TABLE[cls][mod_sel];
    end

endmodule

// File: rtl/dequant_4x4.sv
// -----------------------------------------------------------------------------
// dequant_4x4
//
// Streaming inverse quantizer for 4x4 blocks of coefficients arriving in
// raster order. Each coefficient is reconstructed as
//     out = (in_coef * V(index, QP%6)) << QP/6
// with the QP pair latched on coefficient 0 and held for the whole block.
//
// Pipeline: stage 1 registers the signed product, stage 2 registers the
// shifted and range-reduced result. Both stages advance together whenever
// enable is high and the output register is empty or being drained, so
// in_ready is exactly that advance condition.
//
// Build option:
//   DEQUANT_SAT_EN  defined   : results outside the signed BIT_LENGTH+1 range
//                               clip to max/min and raise out_sat
//                   undefined : results wrap to the low BIT_LENGTH+1 bits and
//                               out_sat stays 0
//
// Ports:
//   clk        in   1             rising-edge clock
//   reset      in   1             synchronous, active-high; beats everything
//   enable     in   1             global advance; 0 freezes all state
//   in_valid   in   1             input coefficient valid
//   in_ready   out  1             block accepts input this cycle
//   in_coef    in   BIT_LENGTH+1  signed quantized level
//   QP_BY_6    in   4             QP/6, sampled with coefficient 0
//   QP_MOD_6   in   3             QP%6, sampled with coefficient 0
//   out_valid  out  1             output coefficient valid
//   out_ready  in   1             downstream accepts output
//   out_coef   out  BIT_LENGTH+1  signed reconstructed coefficient
//   out_index  out  4             raster position of out_coef
//   out_last   out  1             out_index == 15
//   out_sat    out  1             out_coef was clipped
//   busy       out  1             a block is partially received
// -----------------------------------------------------------------------------
module dequant_4x4
    import dequant_4x4_pkg::*;
#(
    parameter int BIT_LENGTH = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [BIT_LENGTH:0]   in_coef,
    input  logic        [3:0]            QP_BY_6,
    input  logic        [2:0]            QP_MOD_6,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [BIT_LENGTH:0]   out_coef,
    output logic        [3:0]            out_index,
    output logic                         out_last,
    output logic                         out_sat,
    output logic                         busy
);

    localparam int W      = BIT_LENGTH + 1;
    // Signed product of a W-bit coefficient and a non-negative V (V_W+1 bits signed).
    localparam int PROD_W = W + V_W + 1;
    // Product widened to hold the largest shift without losing bits.
    localparam int FULL_W = PROD_W + QP_BY_6_MAX;

    localparam logic signed [FULL_W-1:0] COEF_MAX = {{(FULL_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [FULL_W-1:0] COEF_MIN = {{(FULL_W-W+1){1'b1}}, {(W-1){1'b0}}};

`ifdef DEQUANT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Range reduction helpers; both return {sat_flag, coefficient}.
    function automatic logic [W:0] saturate(input logic signed [FULL_W-1:0] x);
        if (x > COEF_MAX) begin
            return {1'b1, COEF_MAX[W-1:0]};
        end
        if (x < COEF_MIN) begin
            return {1'b1, COEF_MIN[W-1:0]};
        end
        return {1'b0, x[W-1:0]};
    endfunction

    function automatic logic [W:0] wrap(input logic signed [FULL_W-1:0] x);
        return {1'b0, x[W-1:0]};
    endfunction

    // ------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------
    logic       advance;
    logic       accept;
    state_e     state;
    logic [3:0] idx_cnt;
    logic [3:0] qp_by_6_lat;
    logic [2:0] qp_mod_6_lat;
    logic       vld_p1;

    assign advance  = enable && (!out_valid || out_ready);
    assign accept   = in_valid && advance;
    assign in_ready = advance;
    assign busy     = (state == ACTIVE);

    // Coefficient 0 uses the QP on the bus in the same cycle it is latched;
    // every later coefficient of the block uses the latched copy.
    logic       first_coef;
    logic [3:0] qp_by_6_in;
    logic [3:0] qp_by_6_cur;
    logic [2:0] qp_mod_6_cur;

    assign first_coef   = (idx_cnt == 4'd0);
    assign qp_by_6_in   = (QP_BY_6 > 4'(QP_BY_6_MAX)) ? 4'(QP_BY_6_MAX) : QP_BY_6;
    assign qp_by_6_cur  = first_coef ? qp_by_6_in : qp_by_6_lat;
    assign qp_mod_6_cur = first_coef ? QP_MOD_6   : qp_mod_6_lat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx_cnt      <= 4'd0;
            qp_by_6_lat  <= 4'd0;
            qp_mod_6_lat <= 3'd0;
            vld_p1       <= 1'b0;
        end else begin
            if (advance) begin
                vld_p1 <= in_valid;
            end
            if (accept) begin
                idx_cnt <= idx_cnt + 4'd1;
                if (first_coef) begin
                    qp_by_6_lat  <= qp_by_6_in;
                    qp_mod_6_lat <= QP_MOD_6;
                end
                case (state)
                    IDLE: begin
                        if (first_coef) begin
                            state <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (idx_cnt == 4'd15) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: scale lookup and signed multiply
    // ------------------------------------------------------------------
    logic        [V_W-1:0]    v;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] prod_p1;
    logic        [3:0]        idx_p1;
    logic        [3:0]        shift_p1;

    dequant_scale_lut u_scale_lut (
        .index    (idx_cnt),
        .qp_mod_6 (qp_mod_6_cur),
        .v        (v)
    );

    // V is zero-extended to a positive signed operand so the multiply keeps the sign.
    assign prod_c = PROD_W'(in_coef) * PROD_W'($signed({1'b0, v}));

    always_ff @(posedge clk) begin
        if (accept) begin
            prod_p1  <= prod_c;
            idx_p1   <= idx_cnt;
            shift_p1 <= qp_by_6_cur;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shift by QP/6 and reduce to the output width
    // ------------------------------------------------------------------
    logic signed [FULL_W-1:0] full_c;
    logic        [W:0]        res_c;

    assign full_c = FULL_W'(prod_p1) <<< shift_p1;
    assign res_c  = SAT_EN ? saturate(full_c) : wrap(full_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_coef  <= '0;
            out_index <= 4'd0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_coef  <= res_c[W-1:0];
                out_sat   <= res_c[W];
                out_index <= idx_p1;
                out_last  <= (idx_p1 == 4'd15);
            end
        end
    end

endmodule

// File: tb/tb_dequant_4x4.sv
// -----------------------------------------------------------------------------
// tb_dequant_4x4
//
// Self-checking bench for dequant_4x4. Inputs are driven just after the rising
// edge; a negedge monitor observes handshakes, feeds a behavioural model that
// reconstructs each coefficient from the QP/position rules with plain integer
// arithmetic, and compares every output transfer against it in order.
// Honours DEQUANT_SAT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_dequant_4x4;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_coef;
    logic        [3:0]   QP_BY_6;
    logic        [2:0]   QP_MOD_6;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_coef;
    logic        [3:0]   out_index;
    logic                out_last;
    logic                out_sat;
    logic                busy;

    always #5 clk = ~clk;

    dequant_4x4 #(.BIT_LENGTH(W-1)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .QP_BY_6   (QP_BY_6),
        .QP_MOD_6  (QP_MOD_6),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_index (out_index),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint coef;
        int     idx;
        bit     sat;
    } exp_t;

    int v_tab [3][6] = '{'{10, 11, 13, 14, 16, 18},
                         '{16, 18, 20, 23, 25, 29},
                         '{13, 14, 16, 18, 20, 23}};

    function automatic exp_t model(input longint c, input int idx, input int qpb, input int qpm);
        exp_t   e;
        int     v;
        int     row;
        longint r;
        longint hi;
        longint lo;
        if (qpm > 5) qpm = 0;
        if (qpb > 8) qpb = 8;
        if (idx inside {0, 2, 8, 10})       row = 0;
        else if (idx inside {5, 7, 13, 15}) row = 1;
        else                                row = 2;
        v  = v_tab[row][qpm];
        r  = c * v * (longint'(1) << qpb);
        hi = (longint'(1) << (W-1)) - 1;
        lo = -(longint'(1) << (W-1));
        e.idx = idx;
        e.sat = 1'b0;
`ifdef DEQUANT_SAT_EN
        if (r > hi) begin
            r = hi;
            e.sat = 1'b1;
        end else if (r < lo) begin
            r = lo;
            e.sat = 1'b1;
        end
`else
        r = r & ((longint'(1) << W) - 1);
        if (r > hi) r = r - (longint'(1) << W);
`endif
        e.coef = r;
        return e;
    endfunction

    exp_t   exp_q[$];
    exp_t   e_pop;
    int     m_idx = 0;
    int     m_qpb = 0;
    int     m_qpm = 0;
    int     out_cnt = 0;
    longint obs_coef [16];
    bit     obs_sat [16];
    int     obs_idx_q[$];

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_idx = 0;
            m_qpb = 0;
            m_qpm = 0;
        end else begin
            check("busy", busy, m_idx != 0);
            check("in_ready", in_ready, enable && (!out_valid || out_ready));
            if (out_valid && out_ready && enable) begin
                check("out_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_pop = exp_q.pop_front();
                    check("out_coef", out_coef, e_pop.coef);
                    check("out_index", out_index, e_pop.idx);
                    check("out_last", out_last, e_pop.idx == 15);
                    check("out_sat", out_sat, e_pop.sat);
                end
                obs_coef[out_index] = out_coef;
                obs_sat[out_index]  = out_sat;
                obs_idx_q.push_back(int'(out_index));
                out_cnt++;
            end
            if (in_valid && in_ready && enable) begin
                if (m_idx == 0) begin
                    m_qpb = int'(QP_BY_6);
                    m_qpm = int'(QP_MOD_6);
                end
                exp_q.push_back(model(longint'(in_coef), m_idx, m_qpb, m_qpm));
                m_idx = (m_idx + 1) % 16;
            end
        end
    end

    // ---------------- drivers ----------------
    logic signed [W-1:0] blk [16];
    bit rand_bp = 1'b0;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 7) != 0);
        end
    end

    task automatic send(input logic signed [W-1:0] c, input logic [3:0] qb, input logic [2:0] qm);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_coef  = c;
        QP_BY_6  = qb;
        QP_MOD_6 = qm;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            done = in_ready && enable && !reset;
            @(posedge clk);
            #1;
        end
        check("send_accepted", done, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int qb, input int qm);
        for (int i = lo; i <= hi; i++) begin
            send(blk[i], 4'(qb), 3'(qm));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            blk[i] = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'(int'($urandom_range(0, 128)) - 64);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (exp_q.size() != 0 || out_valid); k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    logic                fz_valid;
    logic signed [W-1:0] fz_coef;
    logic [3:0]          fz_index;
    int                  cnt0;

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_coef   = '0;
        QP_BY_6   = 4'd0;
        QP_MOD_6  = 3'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_coef", out_coef, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // QP 28, unit coefficients at 0,1,5 and latency of the first accept
        fill_random();
        blk[0] = 1; blk[1] = 1; blk[5] = 1;
        send(blk[0], 4'd4, 3'd4);
        check("latency_c1", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_c2", out_valid, 1);
        check("latency_coef", out_coef, 256);
        send_range(1, 15, 4, 4);
        drain();
        check("qp28_idx1", obs_coef[1], 320);
        check("qp28_idx5", obs_coef[5], 400);

        // QP 0, negative coefficients
        fill_random();
        blk[0] = -3; blk[15] = -1;
        send_range(0, 15, 0, 0);
        drain();
        check("qp0_idx0", obs_coef[0], -30);
        check("qp0_idx15", obs_coef[15], -16);

        // QP 51, overflow at index 5
        fill_random();
        blk[5] = 1000;
        send_range(0, 15, 8, 3);
        drain();
`ifdef DEQUANT_SAT_EN
        check("qp51_coef", obs_coef[5], 32767);
        check("qp51_sat", obs_sat[5], 1);
`else
        check("qp51_coef", obs_coef[5], -10240);
        check("qp51_sat", obs_sat[5], 0);
`endif

        // backpressure: out_ready low 5 cycles mid-block
        fill_random();
        obs_idx_q.delete();
        cnt0 = out_cnt;
        send_range(0, 5, 2, 1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_range(6, 15, 2, 1);
        drain();
        check("bp_count", out_cnt - cnt0, 16);
        for (int i = 0; i < 16 && i < obs_idx_q.size(); i++) begin
            check("bp_order", obs_idx_q[i], i);
        end

        // reset after 7 accepted coefficients
        fill_random();
        send_range(0, 6, 3, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        obs_idx_q.delete();
        fill_random();
        send_range(0, 15, 1, 5);
        drain();
        check("midrst_first_idx", (obs_idx_q.size() > 0) ? obs_idx_q[0] : -1, 0);

        // QP changes mid-block are ignored; enable low freezes outputs
        fill_random();
        blk[8] = 1; blk[9] = 1;
        send_range(0, 7, 4, 4);
        send_range(8, 10, 0, 0);
        enable   = 1'b0;
        fz_valid = out_valid;
        fz_coef  = out_coef;
        fz_index = out_index;
        check("freeze_has_output", fz_valid, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("freeze_valid", out_valid, fz_valid);
            check("freeze_coef", out_coef, fz_coef);
            check("freeze_index", out_index, fz_index);
        end
        enable = 1'b1;
        send_range(11, 15, 0, 0);
        drain();
        check("qpchg_idx8", obs_coef[8], 256);
        check("qpchg_idx9", obs_coef[9], 320);

        // randomized blocks with random backpressure and enable
        rand_bp = 1'b1;
        for (int b = 0; b < 8; b++) begin
            fill_random();
            send_range(0, 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
            send_range(1, 15, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
        end
        rand_bp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        enable    = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/dequant_4x4.md
DEQUANT_4X4 -- requirements
Module: dequant_4x4

Interface
REQ-001 SHALL have parameter BIT_LENGTH, default 15, coefficient MSB index; coefficient width is BIT_LENGTH+1, signed.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  global advance; 0 freezes all state and outputs.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  block accepts input.
- in_coef  in  BIT_LENGTH+1  quantized level, raster order 0..15.
- QP_BY_6  in  4  QP/6, sampled on coefficient 0.
- QP_MOD_6  in  3  QP%6, sampled on coefficient 0.
- out_valid  out  1  output coefficient valid.
- out_ready  in  1  downstream accepts output.
- out_coef  out  BIT_LENGTH+1  reconstructed coefficient.
- out_index  out  4  raster position of out_coef.
- out_last  out  1  out_index==15.
- out_sat  out  1  out_coef was clipped.
- busy  out  1  block partially received.

Function
REQ-003 SHALL transfer input when in_valid&&in_ready&&enable, and output when out_valid&&out_ready&&enable.
REQ-004 SHALL implement a 2-stage pipeline: S1 registers coef*V; S2 registers shift and saturation; latency exactly 2 cycles from accept to out_valid without stall.
REQ-005 SHALL advance the pipeline iff enable && (!out_valid || out_ready); in_ready SHALL equal that advance condition, so no data is lost or duplicated under backpressure.
REQ-006 SHALL keep an internal 4-bit index counter: 0 after reset, +1 per accepted coefficient, wrapping 15->0.
REQ-007 SHALL run FSM IDLE/ACTIVE: IDLE->ACTIVE on accepting index 0; ACTIVE->IDLE on accepting index 15; busy=1 in ACTIVE.
REQ-008 SHALL latch QP_BY_6/QP_MOD_6 on accepting index 0 and use the latched values for all 16 coefficients; QP changes mid-block SHALL be ignored.
REQ-009 SHALL select V by position class: A={0,2,8,10} V=10,11,13,14,16,18; B={5,7,13,15} V=16,18,20,23,25,29; C=others V=13,14,16,18,20,23; indexed by QP_MOD_6 0..5.
REQ-010 SHALL treat QP_MOD_6 of 6 or 7 as 0 and clamp QP_BY_6 above 8 to 8.
REQ-011 SHALL compute out = (in_coef * V) << QP_BY_6 at full precision (min. BIT_LENGTH+15 bits signed); sign is preserved by signed multiply, with no magnitude/sign split.
REQ-012 SHALL forward the index with each coefficient, giving out_index and out_last.

Reset
REQ-013 On reset: out_valid=0, out_coef=0, out_index=0, out_last=0, out_sat=0, busy=0, FSM=IDLE, index counter=0, latched QP=0, both pipeline stages empty.
REQ-014 Reset mid-block SHALL discard all in-flight coefficients; the next accepted coefficient is index 0.
REQ-015 Reset SHALL take priority over enable and all handshakes.

Configuration
REQ-016 With DEQUANT_SAT_EN defined, results outside the signed BIT_LENGTH+1 range SHALL clip to max/min and set out_sat=1 for that coefficient.
REQ-017 Without DEQUANT_SAT_EN, results SHALL truncate to the low BIT_LENGTH+1 bits (two's-complement wrap), and out_sat SHALL be tied 0.

Structure
REQ-018 A shared package SHALL hold the V tables (3 classes x 6), the position-class enum, the FSM state typedef and the QP_BY_6 max constant (8).
REQ-019 V lookup SHALL be a sub-module dequant_scale_lut (index, QP_MOD_6 -> V), combinational; the sub-module is the forward quantizer's counterpart table.

Verification
REQ-020 QP=28 (4,4), coef=1 at indices 0,1,5 -> 256, 320, 400; out_valid 2 cycles after each accept.
REQ-021 QP=0, coef=-3 at index 0 -> -30; coef=-1 at index 15 -> -16.
REQ-022 QP=51 (8,3), coef=1000 at index 5 -> with macro 32767 and out_sat=1; without macro -10240 and out_sat=0.
REQ-023 out_ready held low 5 cycles mid-block -> in_ready low, all 16 outputs in order, indices 0..15, no duplicates.
REQ-024 reset after 7 accepted coefficients -> out_valid=0 next cycle, busy=0, next block's first output has out_index=0.
REQ-025 QP changed from 28 to 0 at index 8 -> indices 8..15 still scaled with QP 28; enable=0 for 3 cycles -> outputs frozen.
